// File: rtl/systolic_operand_feeder_if.sv
// Host write port, stream control and operand outputs of the systolic operand feeder.
// master = host/array control side, slave = feeder side.
interface systolic_operand_feeder_if #(
    parameter int N  = 2,
    parameter int M  = 2,
    parameter int K  = 4,
    parameter int DW = 8
);
    localparam int MX = (N > M) ? N : M;
    localparam int AW = (MX * K > 1) ? $clog2(MX * K) : 1;

    logic          wr_en;
    logic          wr_sel;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          go;
    logic          load;
    logic [N*DW-1:0] A_data;
    logic [M*DW-1:0] B_data;
    logic          finished;
    logic          busy;

    modport master (
        output wr_en, wr_sel, wr_addr, wr_data, go, load,
        input  A_data, B_data, finished, busy
    );

    modport slave (
        input  wr_en, wr_sel, wr_addr, wr_data, go, load,
        output A_data, B_data, finished, busy
    );
endinterface

// File: rtl/systolic_operand_feeder.sv
// Skewed operand source for an N x M systolic MAC array.
// Buffers A (N x K) and B (K x M) and issues one wavefront per load.
module systolic_operand_feeder #(
    parameter int N  = 2,
    parameter int M  = 2,
    parameter int K  = 4,
    parameter int DW = 8
) (
    input  logic clk,
    input  logic rst,
    systolic_operand_feeder_if.slave bus
);
    localparam int TMAX = K + N + M;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] T_LAST = TW'(K - 1);
    localparam logic [TW-1:0] T_SAT  = TW'(TMAX);

    typedef enum logic {IDLE, STREAM} state_e;

    state_e state_q, state_d;
    logic [TW-1:0] t_q, t_d;
    logic          fin_q, fin_d;
    logic [N*DW-1:0] a_out_q, a_out_d;
    logic [M*DW-1:0] b_out_q, b_out_d;
    logic [DW-1:0] a_mem_q [N*K];
    logic [DW-1:0] a_mem_d [N*K];
    logic [DW-1:0] b_mem_q [K*M];
    logic [DW-1:0] b_mem_d [K*M];

    logic busy;
    logic go_ok;
    logic step;
    logic wr_ok;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; STREAM only leaves through reset
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.go) state_d = STREAM;
            STREAM:  state_d = STREAM;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs and control qualifiers
    always_comb begin
        busy  = (state_q == STREAM) && !fin_q;
        go_ok = bus.go && ((state_q == IDLE) || fin_q);
        step  = (state_q == STREAM) && bus.load && !go_ok;
        wr_ok = bus.wr_en && !busy;
    end

    // Step counter and finished flag
    always_comb begin
        t_d   = t_q;
        fin_d = fin_q;
        if (go_ok) begin
            t_d   = '0;
            fin_d = 1'b0;
        end else if (step) begin
            if (t_q == T_LAST) fin_d = 1'b1;
            if (t_q < T_SAT)   t_d   = t_q + 1'b1;
        end
    end

    // Buffer writes land at the same edge as a go, ahead of the first load
    always_comb begin
        a_mem_d = a_mem_q;
        b_mem_d = b_mem_q;
        for (int e = 0; e < N * K; e++) begin
            if (wr_ok && !bus.wr_sel && (int'(bus.wr_addr) == e))
                a_mem_d[e] = bus.wr_data;
        end
        for (int e = 0; e < K * M; e++) begin
            if (wr_ok && bus.wr_sel && (int'(bus.wr_addr) == e))
                b_mem_d[e] = bus.wr_data;
        end
    end

    // Wavefront select: the lag is matched against every valid k,
    // so a lag outside [0,K) simply selects nothing and yields 0.
    always_comb begin
        a_out_d = a_out_q;
        b_out_d = b_out_q;
        if (step) begin
            a_out_d = '0;
            b_out_d = '0;
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < K; k++) begin
                    if (int'(t_q) - i == k)
                        a_out_d[i*DW +: DW] = a_mem_q[i*K + k];
                end
            end
            for (int j = 0; j < M; j++) begin
                for (int k = 0; k < K; k++) begin
                    if (int'(t_q) - j == k)
                        b_out_d[j*DW +: DW] = b_mem_q[k*M + j];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            t_q     <= '0;
            fin_q   <= 1'b0;
            a_out_q <= '0;
            b_out_q <= '0;
            for (int e = 0; e < N * K; e++) a_mem_q[e] <= '0;
            for (int e = 0; e < K * M; e++) b_mem_q[e] <= '0;
        end else begin
            t_q     <= t_d;
            fin_q   <= fin_d;
            a_out_q <= a_out_d;
            b_out_q <= b_out_d;
            for (int e = 0; e < N * K; e++) a_mem_q[e] <= a_mem_d[e];
            for (int e = 0; e < K * M; e++) b_mem_q[e] <= b_mem_d[e];
        end
    end

    assign bus.A_data   = a_out_q;
    assign bus.B_data   = b_out_q;
    assign bus.finished = fin_q;
    assign bus.busy     = busy;
endmodule

// File: tb/tb_systolic_operand_feeder.sv
// Bench for systolic_operand_feeder: directed wavefront table, corner
// sequences and a randomized run against a matrix-level reference model.
module tb_systolic_operand_feeder;
    localparam int N = 2, M = 2, K = 3, DW = 8;

    logic clk = 1'b0;
    logic rst;
    int n_chk = 0;
    int n_err = 0;

    systolic_operand_feeder_if #(.N(N), .M(M), .K(K), .DW(DW)) bus ();

    systolic_operand_feeder #(.N(N), .M(M), .K(K), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a0, a1, b0, b1;
        logic       fin;
    } wave_t;

    wave_t tbl [5];

    // reference model state
    int  mA [2][3];
    int  mB [3][2];
    bit  ms, mf;
    int  mt;
    int  eA [2];
    int  eB [2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm,
                       input logic [7:0] a0, a1, b0, b1,
                       input logic fin, bsy);
        n_chk++;
        if ({bus.A_data, bus.B_data, bus.finished, bus.busy}
            !== {a1, a0, b1, b0, fin, bsy}) begin
            n_err++;
            $display("FAIL %s: A=%h B=%h fin=%b busy=%b required A=%h B=%h fin=%b busy=%b",
                     nm, bus.A_data, bus.B_data, bus.finished, bus.busy,
                     {a1, a0}, {b1, b0}, fin, bsy);
        end
    endtask

    task automatic wr(input logic sel, input int addr, input int data);
        bus.wr_en   = 1'b1;
        bus.wr_sel  = sel;
        bus.wr_addr = 3'(addr);
        bus.wr_data = 8'(data);
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic pulse_go();
        bus.go = 1'b1;
        tick();
        bus.go = 1'b0;
    endtask

    task automatic pulse_load();
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 3; k++) begin
                mA[i][k] = 0;
                mB[k][i] = 0;
            end
        ms = 0; mf = 0; mt = 0;
        eA[0] = 0; eA[1] = 0; eB[0] = 0; eB[1] = 0;
    endtask

    // One clock edge of the reference behaviour for the given inputs
    task automatic model_edge(input bit r, we, sel, input int addr, data,
                              input bit g, ld);
        bit busy_m, go_acc;
        int d;
        if (r) begin
            model_reset();
            return;
        end
        busy_m = ms && !mf;
        go_acc = g && (!ms || mf);
        if (!go_acc && ms && ld) begin
            for (int i = 0; i < 2; i++) begin
                d = mt - i;
                eA[i] = (d >= 0 && d < K) ? mA[i][d] : 0;
                eB[i] = (d >= 0 && d < K) ? mB[d][i] : 0;
            end
            if (mt == K - 1) mf = 1;
            if (mt < K + N + M) mt++;
        end
        if (go_acc) begin
            ms = 1; mt = 0; mf = 0;
        end
        if (we && !busy_m && addr < 6) begin
            if (!sel) mA[addr / 3][addr % 3] = data;
            else      mB[addr / 2][addr % 2] = data;
        end
    endtask

    initial begin
        tbl[0] = '{8'd1, 8'd0, 8'd7,  8'd0,  1'b0};
        tbl[1] = '{8'd2, 8'd4, 8'd9,  8'd8,  1'b0};
        tbl[2] = '{8'd3, 8'd5, 8'd11, 8'd10, 1'b1};
        tbl[3] = '{8'd0, 8'd6, 8'd0,  8'd12, 1'b1};
        tbl[4] = '{8'd0, 8'd0, 8'd0,  8'd0,  1'b1};

        rst = 1'b1;
        bus.wr_en = 1'b0; bus.wr_sel = 1'b0; bus.wr_addr = '0;
        bus.wr_data = '0; bus.go = 1'b0; bus.load = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("reset", 0, 0, 0, 0, 0, 0);

        bus.load = 1'b1;
        tick(); tick();
        bus.load = 1'b0;
        chk("idle_load", 0, 0, 0, 0, 0, 0);

        for (int e = 0; e < 6; e++) wr(1'b0, e, e + 1);
        for (int e = 0; e < 6; e++) wr(1'b1, e, e + 7);

        pulse_go();
        chk("go", 0, 0, 0, 0, 0, 1);

        for (int l = 0; l < 5; l++) begin
            pulse_load();
            chk($sformatf("wave%0d", l + 1), tbl[l].a0, tbl[l].a1,
                tbl[l].b0, tbl[l].b1, tbl[l].fin, !tbl[l].fin);
            tick();
        end

        // hold and write guard mid-stream
        pulse_go();
        pulse_load();
        chk("hold_first", 1, 0, 7, 0, 0, 1);
        repeat (5) tick();
        chk("hold", 1, 0, 7, 0, 0, 1);
        wr(1'b0, 0, 50);
        chk("hold_wr", 1, 0, 7, 0, 0, 1);
        pulse_load();
        chk("guard2", 2, 4, 9, 8, 0, 1);
        tick();
        pulse_load();
        chk("guard3", 3, 5, 11, 10, 1, 0);

        // restart with new value
        wr(1'b0, 0, 99);
        pulse_go();
        chk("restart", 3, 5, 11, 10, 0, 1);
        pulse_load();
        chk("restart_l1", 99, 0, 7, 0, 0, 1);

        // reset mid-stream clears buffers
        pulse_load();
        chk("pre_rst", 2, 4, 9, 8, 0, 1);
        do_reset();
        chk("rst_mid", 0, 0, 0, 0, 0, 0);
        bus.go = 1'b1; bus.load = 1'b1;
        tick();
        bus.go = 1'b0; bus.load = 1'b0;
        chk("go_load_idle", 0, 0, 0, 0, 0, 1);
        pulse_load();
        chk("cleared", 0, 0, 0, 0, 0, 1);

        // go+load when finished, out-of-range writes
        do_reset();
        wr(1'b0, 0, 5);
        wr(1'b0, 2, 8);
        wr(1'b1, 0, 6);
        wr(1'b0, 6, 77);
        wr(1'b1, 7, 88);
        pulse_go();
        repeat (3) pulse_load();
        chk("fin6", 8, 0, 0, 0, 1, 0);
        bus.go = 1'b1; bus.load = 1'b1;
        tick();
        bus.go = 1'b0; bus.load = 1'b0;
        chk("go_load", 8, 0, 0, 0, 0, 1);
        pulse_load();
        chk("after_go_load", 5, 0, 6, 0, 0, 1);
        pulse_load();
        chk("oor_l2", 0, 0, 0, 0, 0, 1);

        // randomized run against the reference model
        do_reset();
        model_reset();
        for (int c = 0; c < 600; c++) begin
            bit r, we, sel, g, ld;
            int addr, data;
            r    = ($urandom_range(99) == 0);
            we   = ($urandom_range(9) < 4);
            sel  = 1'($urandom_range(1));
            addr = int'($urandom_range(7));
            data = int'($urandom_range(255));
            g    = ($urandom_range(9) == 0);
            ld   = ($urandom_range(1) == 1);
            rst = r;
            bus.wr_en = we; bus.wr_sel = sel;
            bus.wr_addr = 3'(addr); bus.wr_data = 8'(data);
            bus.go = g; bus.load = ld;
            model_edge(r, we, sel, addr, data, g, ld);
            tick();
            chk($sformatf("rand%0d", c), 8'(eA[0]), 8'(eA[1]),
                8'(eB[0]), 8'(eB[1]), mf, ms && !mf);
        end
        rst = 1'b0;
        bus.wr_en = 1'b0; bus.go = 1'b0; bus.load = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
